word_serializer: RTL and testbench
==================================

# word_serializer

Parallel-in, serial-out converter for the team's enable-gated register datapath: accepts an N-bit word through a load/ready handshake and shifts it out MSB-first, one bit per cycle, with a valid strobe, last-bit marker and completion pulse. It is the consumer end of the registered parallel bus: it drains a held register word onto a single-bit link. Downstream backpressure is supported through a stall input.

## Interface
- N, default 30, word width in bits; legal range 2..64.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clock clk.
- load  in  1  request to capture d; honoured only when ready=1.
- d  in  N  parallel word; sampled on the edge where load&ready=1.
- stall  in  1  downstream hold; freezes shifting while in SHIFT/PARITY.
- ready  out  1  block idle and able to accept a word.
- sout  out  1  serial data bit.
- sout_valid  out  1  sout carries a payload (or parity) bit this cycle.
- last  out  1  qualifies the final bit of the frame.
- done  out  1  one-cycle pulse after the frame completes.

## Operation
- All outputs are registered.
- Reset values:
  - State: IDLE.
  - Outputs: ready=1, sout=0, sout_valid=0, last=0, done=0.
  - Internal: shift register and bit counter are 0.
- States:
  - IDLE: ready=1. On load=1, capture d into the shift register, clear the bit counter and go to SHIFT. On load=0, stay.
  - SHIFT: sout is the shift register MSB and sout_valid=1. Each edge with stall=0 shifts left by one, filling with 0, and increments the counter.
    - last=1 while the counter equals N-1 (without parity).
    - On the edge that consumes bit index N-1, go to DONE, or to PARITY when parity is compiled in.
  - PARITY (only with parity compiled in): sout is the even parity of the captured word, sout_valid=1, last=1. Leave for DONE on an edge with stall=0.
  - DONE: done=1, sout_valid=0, ready=0. Unconditionally go to IDLE next edge.
- ready is 0 in SHIFT, PARITY and DONE. load asserted while ready=0 is ignored and is not queued.
- stall:
  - In SHIFT or PARITY, stall holds the state, counter, sout, sout_valid and last unchanged.
  - stall has no effect in IDLE or DONE.
- The bit counter is ceil(log2(N)) bits wide and must not wrap within a frame. Its compare to N-1 is unsigned at counter width.
- In IDLE, sout is 0.
- reset asserted in any state, including mid-frame or during a stall, aborts the frame. All outputs and state return to their reset values on that edge, and no done pulse is generated.
- load and reset on the same edge: reset wins and the word is discarded.

## Timing
- Load accepted at edge E0: the first bit d[N-1] is visible with sout_valid=1 after E0.
- Without stall:
  - Bit d[N-1-k] is visible after edge E0+k.
  - last is visible after E0+N-1.
  - done pulses after E0+N.
  - ready returns after E0+N+1.
  - The next load can be sampled at edge E0+N+2.
  - Throughput is one word per N+2 cycles, or N+3 cycles with parity.
- Each stalled cycle adds exactly one cycle to the remaining latency.

## Configuration
- Macro: WORD_SERIALIZER_PARITY_EN.
- Defined: the PARITY state is present and one even-parity bit follows d[0]. last moves to the parity bit; last is 0 on d[0].
- Undefined: there is no PARITY state and no parity logic. SHIFT exits directly to DONE, and last marks d[0].

## Structure
- Shared package word_serializer_pkg holds:
  - the state typedef (IDLE, SHIFT, PARITY, DONE) as a 2-bit enum;
  - the N bounds constants;
  - a function computing counter width from N.
- One sub-module: word_serializer_bitcnt, the clear/increment/hold counter with a terminal-count compare to N-1.
- The FSM, shift register and output registers live in the top module.

## Test plan
All scenarios run with N=8.
- Reset, then idle 5 cycles: ready=1, sout_valid=0, sout=0, done=0 throughout.
- load with d=8'hA5, no stall: sout sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles. last is set on the 8th bit only, done pulses on the next cycle, and ready returns one cycle later.
- d=8'hF0 with stall=1 for 3 cycles after the 2nd bit: the 2nd bit is held with sout_valid=1 for 4 cycles total, the sequence completes intact, and done arrives 3 cycles later than without stall.
- load pulsed with d=8'h3C during a frame: it is ignored, and the current frame's bits and done timing are unchanged.
- reset asserted after the 4th bit of 8'hFF: the next cycle shows ready=1, sout_valid=0, and no done pulse. A following load of 8'h01 serializes correctly.
- With WORD_SERIALIZER_PARITY_EN defined, d=8'h07: after bits 0,0,0,0,0,1,1,1 comes a 9th bit of 1 with last=1, and done follows on the next cycle.

Source files
------------

// File: rtl/word_serializer_pkg.sv
// rtl/word_serializer_pkg.sv - shared types, bounds and counter-width helper for word_serializer
package word_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int unsigned N_MIN     = 2;
    localparam int unsigned N_MAX     = 64;
    localparam int unsigned N_DEFAULT = 30;

    // Bit counter only needs to reach N-1, so ceil(log2(N)) bits, never below one.
    function automatic int unsigned cnt_width(input int unsigned n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/word_serializer_bitcnt.sv
// rtl/word_serializer_bitcnt.sv - clear/increment/hold bit counter with terminal-count compare to N-1
module word_serializer_bitcnt
    import word_serializer_pkg::*;
#(
    parameter int unsigned N  = N_DEFAULT,
    parameter int unsigned CW = cnt_width(N)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o,
    output logic tc_next_o
);

    localparam logic [CW-1:0] TERM = CW'(N - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, increments stop at the terminal value so a frame never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != TERM)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o      = (cnt_q == TERM);
    assign tc_next_o = (cnt_d == TERM);

endmodule

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - parallel-in MSB-first serial-out converter; optional even parity bit via WORD_SERIALIZER_PARITY_EN
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] d,
    input  logic         stall,
    output logic         ready,
    output logic         sout,
    output logic         sout_valid,
    output logic         last,
    output logic         done
);

    state_t state_q;
    state_t state_d;

    logic [N-1:0] shreg_q;
    logic [N-1:0] shreg_d;

    logic ready_q, ready_d;
    logic sout_q, sout_d;
    logic sout_valid_q, sout_valid_d;
    logic last_q, last_d;
    logic done_q, done_d;

    logic accept;
    logic advance;
    logic cnt_tc;
    logic cnt_tc_next;

    // A word is taken only from IDLE; stall only matters while bits are on the link.
    assign accept  = (state_q == IDLE) && load;
    assign advance = (state_q == SHIFT) && !stall;

    word_serializer_bitcnt #(
        .N (N)
    ) u_bitcnt (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (accept),
        .inc_i     (advance),
        .tc_o      (cnt_tc),
        .tc_next_o (cnt_tc_next)
    );

`ifdef WORD_SERIALIZER_PARITY_EN
    logic par_q;
    logic par_d;

    // Parity of the whole word is latched at capture, the shift register is drained by then.
    always_comb begin
        par_d = par_q;
        if (accept) begin
            par_d = ^d;
        end
    end

    // Parity register.
    always_ff @(posedge clk) begin
        if (reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and shift register update.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = SHIFT;
                    shreg_d = d;
                end
            end
            SHIFT: begin
                if (!stall) begin
                    shreg_d = {shreg_q[N-2:0], 1'b0};
                    if (cnt_tc) begin
`ifdef WORD_SERIALIZER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef WORD_SERIALIZER_PARITY_EN
            PARITY: begin
                if (!stall) begin
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output values derived from the upcoming state so every output is a plain register.
    always_comb begin
        ready_d      = (state_d == IDLE);
        sout_d       = 1'b0;
        sout_valid_d = 1'b0;
        last_d       = 1'b0;
        done_d       = 1'b0;
        case (state_d)
            SHIFT: begin
                sout_d       = shreg_d[N-1];
                sout_valid_d = 1'b1;
`ifndef WORD_SERIALIZER_PARITY_EN
                last_d       = cnt_tc_next;
`endif
            end
`ifdef WORD_SERIALIZER_PARITY_EN
            PARITY: begin
                sout_d       = par_q;
                sout_valid_d = 1'b1;
                last_d       = 1'b1;
            end
`endif
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                sout_d = 1'b0;
            end
        endcase
    end

    // Shift register and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q      <= '0;
            ready_q      <= 1'b1;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            last_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            shreg_q      <= shreg_d;
            ready_q      <= ready_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            last_q       <= last_d;
            done_q       <= done_d;
        end
    end

    assign ready      = ready_q;
    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign last       = last_q;
    assign done       = done_q;

endmodule

// File: tb/tb_word_serializer.sv
// tb/tb_word_serializer.sv - self-checking bench for word_serializer (N=8), table vectors plus random run against a frame model
module tb_word_serializer;

    localparam int N = 8;
`ifdef WORD_SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB = N + PAR;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic         stall;
    logic [N-1:0] d;
    logic         ready;
    logic         sout;
    logic         sout_valid;
    logic         last;
    logic         done;

    word_serializer #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .d          (d),
        .stall      (stall),
        .ready      (ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .last       (last),
        .done       (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_model = 1'b0;

    // Frame model: phase 0 idle, 1 bits on the link, 2 done pulse.
    int   m_phase = 0;
    int   m_pos   = 0;
    logic m_bits [0:NB-1];

    typedef struct {
        logic       r;
        logic       l;
        logic       s;
        logic [7:0] d;
        logic [4:0] exp;   // {ready, sout, sout_valid, last, done}
    } vec_t;

    vec_t vecs[$];

    function automatic logic [4:0] outs();
        return {ready, sout, sout_valid, last, done};
    endfunction

    function automatic logic [4:0] m_exp();
        if (m_phase == 1) return {1'b0, m_bits[m_pos], 1'b1, (m_pos == NB - 1), 1'b0};
        if (m_phase == 2) return 5'b00001;
        return 5'b10000;
    endfunction

    function automatic void m_update(input logic r, input logic l, input logic s, input logic [N-1:0] dv);
        if (r) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (l) begin
                for (int i = 0; i < N; i++) m_bits[i] = dv[N-1-i];
                if (PAR == 1) m_bits[NB-1] = ^dv;
                m_pos   = 0;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (!s) begin
                m_pos++;
                if (m_pos == NB) m_phase = 2;
            end
        end else begin
            m_phase = 0;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic l, input logic s, input logic [N-1:0] dv);
        reset = r;
        load  = l;
        stall = s;
        d     = dv;
        @(posedge clk);
        m_update(r, l, s, dv);
        cyc++;
        #1;
        if (chk_model) check("model", 32'(outs()), 32'(m_exp()));
    endtask

    function automatic void add(input logic r, input logic l, input logic s, input logic [7:0] dv, input logic [4:0] e);
        vec_t v;
        v.r = r; v.l = l; v.s = s; v.d = dv; v.exp = e;
        vecs.push_back(v);
    endfunction

    function automatic void add_frame(input logic [7:0] w);
        add(1'b0, 1'b1, 1'b0, w, {1'b0, w[7], 1'b1, 1'b0, 1'b0});
        for (int k = 1; k < N; k++) add(1'b0, 1'b0, 1'b0, 8'h00, {1'b0, w[7-k], 1'b1, (k == N - 1) && (PAR == 0), 1'b0});
        if (PAR == 1) add(1'b0, 1'b0, 1'b0, 8'h00, {1'b0, ^w, 1'b1, 1'b1, 1'b0});
        add(1'b0, 1'b0, 1'b0, 8'h00, 5'b00001);
        add(1'b0, 1'b0, 1'b0, 8'h00, 5'b10000);
    endfunction

    initial begin
        int k;
        reset = 1'b1;
        load  = 1'b0;
        stall = 1'b0;
        d     = '0;

        add(1'b1, 1'b0, 1'b0, 8'h00, 5'b10000);
        for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 1'b0, 8'h00, 5'b10000);
        add_frame(8'hA5);
`ifdef WORD_SERIALIZER_PARITY_EN
        add_frame(8'h07);
`endif

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].l, vecs[i].s, vecs[i].d);
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        chk_model = 1'b1;

        // Stall for three cycles while the second bit of F0 is on the link.
        step(1'b0, 1'b1, 1'b0, 8'hF0);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            check("f0_hold", 32'({sout, sout_valid}), 32'(2'b11));
        end
        k = 4;
        while (!done && k < 40) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
            k++;
        end
        check("f0_done_latency", 32'(k), 32'(NB + 3));
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // A load pulse in mid-frame must not disturb the frame or its done timing.
        step(1'b0, 1'b1, 1'b0, 8'h96);
        k = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
            k++;
        end
        step(1'b0, 1'b1, 1'b0, 8'h3C);
        k++;
        while (!done && k < 40) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
            k++;
        end
        check("ign_load_latency", 32'(k), 32'(NB));
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("ign_load_ready", 32'(ready), 32'(1));

        // Reset after the 4th bit of FF aborts without a done pulse.
        step(1'b0, 1'b1, 1'b0, 8'hFF);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("rst_abort", 32'({ready, sout_valid, done}), 32'(3'b100));
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("rst_no_done", 32'(done), 32'(0));
        step(1'b0, 1'b1, 1'b0, 8'h01);
        k = 0;
        while (!done && k < 40) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
            k++;
        end
        check("post_rst_latency", 32'(k), 32'(NB));
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Load and reset on the same edge: reset wins.
        step(1'b1, 1'b1, 1'b0, 8'hAA);
        check("rst_beats_load", 32'(outs()), 32'(5'b10000));

        // Random traffic against the frame model.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 35,
                 $urandom_range(0, 99) < 25, N'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
